// File: rtl/cdb_arbiter.sv
// cdb_arbiter: producer end of the common data bus.
// Each functional unit owns one holding slot filled through a valid/ready
// handshake. One full slot per cycle is picked round-robin and broadcast as a
// registered {valid, tag, data} beat. flush drops every pending result.
// Optional build macro CDB_ARBITER_CONFLICT_CNT_EN adds the conflict_count
// output, which counts cycles with two or more full slots.
module cdb_arbiter #(
  parameter int N_SRC     = 4,
  parameter int ROB_WIDTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic [N_SRC-1:0]             req_valid,
  input  logic [N_SRC*ROB_WIDTH-1:0]   req_tag,
  input  logic [N_SRC*32-1:0]          req_data,
  output logic [N_SRC-1:0]             req_ready,
  output logic                         cdb_valid,
  output logic [ROB_WIDTH-1:0]         cdb_tag,
  output logic [31:0]                  cdb_data
`ifdef CDB_ARBITER_CONFLICT_CNT_EN
  ,
  output logic [31:0]                  conflict_count
`endif
);

  localparam int PW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  logic [N_SRC-1:0]     full_vec;
  logic [ROB_WIDTH-1:0] tag_arr  [N_SRC];
  logic [31:0]          data_arr [N_SRC];
  logic [N_SRC-1:0]     grant;
  logic [PW-1:0]        grant_idx;
  logic                 any_full;
  logic [PW:0]          arb_sum;

  logic [PW-1:0]        rr_ptr_q, rr_ptr_d;
  logic                 cdb_valid_q, cdb_valid_d;
  logic [ROB_WIDTH-1:0] cdb_tag_q, cdb_tag_d;
  logic [31:0]          cdb_data_q, cdb_data_d;

  // Round-robin search over full slots, starting at rr_ptr and wrapping.
  always_comb begin
    grant_idx = '0;
    any_full  = 1'b0;
    arb_sum   = '0;
    for (int k = 0; k < N_SRC; k++) begin
      arb_sum = {1'b0, rr_ptr_q} + (PW+1)'(k);
      if (arb_sum >= (PW+1)'(N_SRC)) begin
        arb_sum = arb_sum - (PW+1)'(N_SRC);
      end
      if (!any_full && full_vec[arb_sum[PW-1:0]]) begin
        any_full  = 1'b1;
        grant_idx = arb_sum[PW-1:0];
      end
    end
    grant = '0;
    if (any_full) begin
      grant[grant_idx] = 1'b1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_SRC; gi++) begin : g_slot
      logic                 full_q, full_d;
      logic [ROB_WIDTH-1:0] tag_q, tag_d;
      logic [31:0]          data_q, data_d;
      logic                 accept;

      // A slot being drained this cycle can take a new result at the same edge.
      assign req_ready[gi] = !full_q || grant[gi];
      assign accept        = req_valid[gi] && req_ready[gi] && !flush;
      assign full_vec[gi]  = full_q;
      assign tag_arr[gi]   = tag_q;
      assign data_arr[gi]  = data_q;

      // Slot next state: flush kills, refill beats the grant-clear.
      always_comb begin
        full_d = full_q;
        tag_d  = tag_q;
        data_d = data_q;
        if (flush) begin
          full_d = 1'b0;
        end else if (accept) begin
          full_d = 1'b1;
          tag_d  = req_tag[gi*ROB_WIDTH +: ROB_WIDTH];
          data_d = req_data[gi*32 +: 32];
        end else if (grant[gi]) begin
          full_d = 1'b0;
        end
      end

      // Slot registers.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          full_q <= 1'b0;
          tag_q  <= '0;
          data_q <= '0;
        end else begin
          full_q <= full_d;
          tag_q  <= tag_d;
          data_q <= data_d;
        end
      end
    end
  endgenerate

  // CDB beat and pointer next state; tag/data hold when no beat goes out.
  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    cdb_valid_d = 1'b0;
    cdb_tag_d   = cdb_tag_q;
    cdb_data_d  = cdb_data_q;
    if (!flush && any_full) begin
      cdb_valid_d = 1'b1;
      cdb_tag_d   = tag_arr[grant_idx];
      cdb_data_d  = data_arr[grant_idx];
      rr_ptr_d    = (grant_idx == PW'(N_SRC-1)) ? '0 : grant_idx + 1'b1;
    end
  end

  // CDB output and round-robin pointer registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr_q    <= '0;
      cdb_valid_q <= 1'b0;
      cdb_tag_q   <= '0;
      cdb_data_q  <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      cdb_valid_q <= cdb_valid_d;
      cdb_tag_q   <= cdb_tag_d;
      cdb_data_q  <= cdb_data_d;
    end
  end

  assign cdb_valid = cdb_valid_q;
  assign cdb_tag   = cdb_tag_q;
  assign cdb_data  = cdb_data_q;

`ifdef CDB_ARBITER_CONFLICT_CNT_EN
  logic [31:0] conflict_count_q, conflict_count_d;

  // Saturating count of contended cycles; flush does not clear it.
  always_comb begin
    conflict_count_d = conflict_count_q;
    if (!flush && ($countones(full_vec) > 1) && (conflict_count_q != 32'hFFFF_FFFF)) begin
      conflict_count_d = conflict_count_q + 32'd1;
    end
  end

  // Conflict counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      conflict_count_q <= '0;
    end else begin
      conflict_count_q <= conflict_count_d;
    end
  end

  assign conflict_count = conflict_count_q;
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed scenarios plus randomized traffic, checked every
// cycle against a slot-level behavioural model of the CDB arbiter.
module tb_cdb_arbiter;
  localparam int N  = 4;
  localparam int RW = 4;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            flush = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N*RW-1:0] req_tag = '0;
  logic [N*32-1:0] req_data = '0;
  logic [N-1:0]    req_ready;
  logic            cdb_valid;
  logic [RW-1:0]   cdb_tag;
  logic [31:0]     cdb_data;
`ifdef CDB_ARBITER_CONFLICT_CNT_EN
  logic [31:0]     conflict_count;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cdb_arbiter #(.N_SRC(N), .ROB_WIDTH(RW)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .req_valid(req_valid), .req_tag(req_tag), .req_data(req_data),
    .req_ready(req_ready),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data)
`ifdef CDB_ARBITER_CONFLICT_CNT_EN
    , .conflict_count(conflict_count)
`endif
  );

  // Behavioural model: one entry per slot, pointer as a plain integer.
  bit          m_full [N];
  bit [RW-1:0] m_tag  [N];
  bit [31:0]   m_data [N];
  bit          m_acc  [N];
  int          m_rr = 0;
  bit          m_cv = 0;
  bit [RW-1:0] m_ct = '0;
  bit [31:0]   m_cd = '0;
  bit [31:0]   m_conf = '0;
  bit          m_flushed = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic int winner();
    for (int k = 0; k < N; k++) begin
      if (m_full[(m_rr + k) % N]) return (m_rr + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] model_ready();
    logic [N-1:0] r;
    int g;
    g = winner();
    for (int i = 0; i < N; i++) r[i] = !m_full[i] || (g == i);
    return r;
  endfunction

  task automatic model_step();
    int g;
    int nfull;
    logic [N-1:0] rdy;
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        m_full[i] = 0; m_tag[i] = '0; m_data[i] = '0; m_acc[i] = 0;
      end
      m_rr = 0; m_cv = 0; m_ct = '0; m_cd = '0; m_conf = '0; m_flushed = 0;
    end else begin
      g = winner();
      rdy = model_ready();
      nfull = 0;
      for (int i = 0; i < N; i++) nfull += int'(m_full[i]);
      if (!flush && nfull >= 2 && m_conf != 32'hFFFF_FFFF) m_conf = m_conf + 1;
      if (flush) begin
        for (int i = 0; i < N; i++) begin m_full[i] = 0; m_acc[i] = 0; end
        m_cv = 0;
      end else begin
        if (g >= 0) begin
          m_cv = 1; m_ct = m_tag[g]; m_cd = m_data[g];
          m_full[g] = 0;
          m_rr = (g + 1) % N;
        end else begin
          m_cv = 0;
        end
        for (int i = 0; i < N; i++) begin
          m_acc[i] = req_valid[i] && rdy[i];
          if (m_acc[i]) begin
            m_full[i] = 1;
            m_tag[i]  = req_tag[i*RW +: RW];
            m_data[i] = req_data[i*32 +: 32];
          end
        end
      end
      m_flushed = flush;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Per-cycle compare of every DUT output against the model.
  initial forever begin
    @(negedge clk);
    check("m_cdb_valid", cdb_valid, m_cv);
    check("m_cdb_tag", cdb_tag, m_ct);
    check("m_cdb_data", cdb_data, m_cd);
    check("m_req_ready", req_ready, model_ready());
`ifdef CDB_ARBITER_CONFLICT_CNT_EN
    check("m_conflict_count", conflict_count, m_conf);
`endif
  end

  task automatic drive(input int i, input bit [RW-1:0] t, input bit [31:0] d);
    req_valid[i] = 1'b1;
    req_tag[i*RW +: RW] = t;
    req_data[i*32 +: 32] = d;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1 reset = 1'b1;
    req_valid = '0;
    flush = 1'b0;
    #1 check("async_reset_valid", cdb_valid, 1'b0);
    check("async_reset_ready", req_ready, {N{1'b1}});
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int load;
    bit hold;
    repeat (2) @(negedge clk);
    check("reset_ready", req_ready, 4'hF);
    check("reset_valid", cdb_valid, 1'b0);
    check("reset_tag", cdb_tag, 4'h0);
    check("reset_data", cdb_data, 32'h0);
    reset = 1'b0;

    // Single source: src2, tag 5.
    drive(2, 4'd5, 32'hDEAD_BEEF);
    @(negedge clk);
    req_valid = '0;
    check("single_ready2_a", req_ready[2], 1'b1);
    check("single_no_beat_yet", cdb_valid, 1'b0);
    @(negedge clk);
    check("single_valid", cdb_valid, 1'b1);
    check("single_tag", cdb_tag, 4'd5);
    check("single_data", cdb_data, 32'hDEAD_BEEF);
    check("single_ready2_b", req_ready[2], 1'b1);
    @(negedge clk);
    check("single_one_cycle", cdb_valid, 1'b0);
    check("single_tag_held", cdb_tag, 4'd5);

    // Contention: four sources at once after reset.
    do_reset();
    for (int i = 0; i < N; i++) drive(i, RW'(i + 1), 32'h100 + 32'(i));
    @(negedge clk);
    req_valid = '0;
    check("cont_no_beat_yet", cdb_valid, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check("cont_valid", cdb_valid, 1'b1);
      check("cont_tag", cdb_tag, RW'(k));
    end
    @(negedge clk);
    check("cont_fifth_idle", cdb_valid, 1'b0);
`ifdef CDB_ARBITER_CONFLICT_CNT_EN
    check("conflict_after_drain", conflict_count, 32'd3);
`endif

    // Fairness: src0 and src3 continuously valid.
    do_reset();
    drive(0, 4'hA, 32'h0000_00AA);
    drive(3, 4'hD, 32'h0000_00DD);
    @(negedge clk);
    check("rr_no_beat_yet", cdb_valid, 1'b0);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("rr_valid", cdb_valid, 1'b1);
      check("rr_tag", cdb_tag, (k % 2 == 0) ? 4'hA : 4'hD);
    end
    req_valid = '0;
    repeat (3) @(negedge clk);

    // Backpressure: src0 full and wins first, src1 offers 7 then 8.
    do_reset();
    drive(0, 4'h3, 32'h33);
    drive(1, 4'h7, 32'h77);
    @(negedge clk);
    req_valid[0] = 1'b0;
    drive(1, 4'h8, 32'h88);
    check("bp_ready1_low", req_ready[1], 1'b0);
    @(negedge clk);
    check("bp_tag_first", cdb_tag, 4'h3);
    check("bp_ready1_back", req_ready[1], 1'b1);
    @(negedge clk);
    req_valid = '0;
    check("bp_tag7", cdb_tag, 4'h7);
    @(negedge clk);
    check("bp_valid8", cdb_valid, 1'b1);
    check("bp_tag8", cdb_tag, 4'h8);
    check("bp_data8", cdb_data, 32'h88);
    @(negedge clk);
    check("bp_idle", cdb_valid, 1'b0);

    // Flush: three slots full, request in the flush cycle is dropped.
    do_reset();
    drive(0, 4'h1, 32'h1); drive(1, 4'h2, 32'h2); drive(2, 4'h3, 32'h3);
    @(negedge clk);
    req_valid = '0;
    flush = 1'b1;
    drive(3, 4'h9, 32'h9);
    @(negedge clk);
    flush = 1'b0;
    req_valid = '0;
    check("flush_valid_low", cdb_valid, 1'b0);
    check("flush_ready_all", req_ready, 4'hF);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("flush_no_beats", cdb_valid, 1'b0);
    end
    drive(0, 4'hE, 32'hCAFE_0000);
    @(negedge clk);
    req_valid = '0;
    check("post_flush_wait", cdb_valid, 1'b0);
    @(negedge clk);
    check("post_flush_valid", cdb_valid, 1'b1);
    check("post_flush_tag", cdb_tag, 4'hE);

    // Randomized traffic with occasional flush and mid-run reset.
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (reset) reset = 1'b0;
      load = (cyc / 500) % 3 == 0 ? 30 : ((cyc / 500) % 3 == 1 ? 70 : 95);
      for (int i = 0; i < N; i++) begin
        hold = req_valid[i] && !m_acc[i] && !m_flushed;
        if (!hold) begin
          req_valid[i] = ($urandom_range(0, 99) < load);
          req_tag[i*RW +: RW] = RW'($urandom);
          req_data[i*32 +: 32] = $urandom;
        end
      end
      flush = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 599) == 0) begin
        #1 reset = 1'b1;
        req_valid = '0;
        flush = 1'b0;
      end
    end
    @(negedge clk);
    reset = 1'b0;
    req_valid = '0;
    flush = 1'b0;
    repeat (6) @(negedge clk);
    check("final_idle", cdb_valid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
